result_bcd_formatter: RTL and testbench
=======================================

Name: result_bcd_formatter

Overview:
- Output end of the calculator datapath. Takes one 11-bit result bus from the arithmetic library: bits [9:0] hold a two's-complement value and bit [10] is the overflow flag.
- Produces a sign flag, an error flag and three BCD digits for the display driver.
- Conversion is sequential double-dabble, one bit per clock. Valid/ready handshake on both sides.

Parameters:
- W, 10, data bits excluding the overflow bit; 10^DIGITS must exceed 2^(W-1).
- DIGITS, 3, number of BCD output digits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- a  input  11  result bus: [10] overflow, [9:0] two's-complement value
- a_valid  input  1  a is presented
- a_ready  output  1  block can accept a
- q_ready  input  1  downstream consumes the output
- q_valid  output  1  q_* outputs are valid
- q_neg  output  1  value is negative
- q_err  output  1  overflow was flagged; digits are blank
- q_d2  output  4  hundreds digit, BCD
- q_d1  output  4  tens digit, BCD
- q_d0  output  4  units digit, BCD

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high. With rst high at an edge:
  - state goes to IDLE;
  - q_valid, q_neg, q_err and all digits go to 0;
  - any conversion in progress is discarded.
- a_ready = (state == IDLE) and not rst. It is a combinational decode of registered state.
- States:
  - IDLE: on a_valid & a_ready at an edge, capture a and go to ABS.
  - ABS (one cycle):
    - If captured [10]=1: q_err=1, q_neg=0, digits=4'hF (blank code), go to DONE.
    - Else: q_neg = captured [9]; magnitude = two's-complement absolute value, W+1 bits wide so -512 gives 512 with no wrap. Clear the BCD shift register, load the bit counter with W, go to SHIFT.
  - SHIFT (W cycles): each cycle, every BCD digit >= 5 gets +3, then {bcd, mag} shifts left by 1. Counter decrements; leave SHIFT when the counter reaches 0.
  - DONE: q_valid=1. Digits register from the BCD shift register when leaving SHIFT. On q_valid & q_ready at an edge, go to IDLE and drop q_valid.
- Latency, counted from the accepting edge:
  - normal value: q_valid rises at edge +W+2 (12 with defaults);
  - overflow value: q_valid rises at edge +2.
- Stability: while q_valid=1 and q_ready=0, all q_* outputs hold stable and a_ready stays 0. a_valid is ignored outside IDLE.
- Back-to-back: a_ready rises the cycle after the q handshake edge. There is no pass-through in the same cycle.
- Zero: 0 gives q_neg=0 and digits 0,0,0. Negative zero cannot occur.
- Bit 9 of a is ignored when bit 10 is set.

Decomposition:
- Shared package calc_pkg holds:
  - BUS_W = 11, OVF_BIT = 10;
  - BCD_BLANK = 4'hF;
  - state enum {IDLE, ABS, SHIFT, DONE}.
- Sub-module bcd_add3: combinational 4-bit "if >= 5 add 3" cell, instantiated DIGITS times inside the shift stage.
- Control FSM, counter and registers stay in the top module.

Test Plan:
1. a=11'h07B (123), q_ready=1 → q_valid at accept+12; q_neg=0, q_err=0, digits 1,2,3; one-cycle q_valid pulse.
2. a=11'h200 (-512) → q_neg=1, digits 5,1,2. a=11'h3FF (-1) → q_neg=1, digits 0,0,1. a=11'h000 → q_neg=0, digits 0,0,0.
3. a=11'h47B (overflow set) → q_valid at accept+2; q_err=1, q_neg=0, digits F,F,F.
4. Convert 11'h1FF (511) with q_ready=0 for 5 cycles after q_valid:
   - outputs hold 5,1,1 and a_ready stays 0;
   - a_valid pulses during the hold are ignored;
   - q_ready=1 → next cycle a_ready=1.
5. Reset mid-conversion: assert rst during the 4th SHIFT cycle of 11'h07B → next edge all outputs 0 and state IDLE. Then convert 11'h1FF → digits 5,1,1 at the normal latency.
6. Back-to-back stream of 11'h001, 11'h3F6 (-10), 11'h064 (100), q_ready=1 → results 001/+, 010/-, 100/+. Each accept occurs exactly one cycle after the previous q handshake.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator output path.
// Bus layout, blank digit code and formatter FSM states.
package calc_pkg;

  localparam int BUS_W = 11;
  localparam int OVF_BIT = 10;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/result_bcd_formatter_bcd_add3.sv
// Double-dabble correction cell.
// Adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] y
);

  // correct the digit so the following shift carries properly
  always_comb begin
    y = d;
    if (d >= 4'd5) y = d + 4'd3;
  end

endmodule

// File: rtl/result_bcd_formatter.sv
// Result bus to sign/error/BCD formatter.
// Sequential double-dabble, one bit per clock, valid/ready on both sides.
module result_bcd_formatter
  import calc_pkg::*;
#(
  parameter int W = 10,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             q_ready,
  output logic             q_valid,
  output logic             q_neg,
  output logic             q_err,
  output logic [3:0]       q_d2,
  output logic [3:0]       q_d1,
  output logic [3:0]       q_d0
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  state_t          state;
  logic [BUS_W-1:0] cap;
  logic [W:0]      mag;
  logic [W:0]      mag_abs;
  logic [BW-1:0]   bcd;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   dig;
  logic [CW-1:0]   cnt;

  assign a_ready = (state == IDLE) && !rst;

  assign q_d0 = dig[3:0];
  assign q_d1 = dig[7:4];
  assign q_d2 = dig[11:8];

  // magnitude one bit wider than the data so the most negative value fits
  always_comb begin
    mag_abs = {1'b0, cap[W-1:0]};
    if (cap[W-1])
      mag_abs = ~{cap[W-1], cap[W-1:0]} + {{W{1'b0}}, 1'b1};
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_add3 u_add3 (
      .d(bcd[4*i +: 4]),
      .y(bcd_adj[4*i +: 4])
    );
  end

  // control FSM, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cap     <= '0;
      mag     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      dig     <= '0;
      q_valid <= 1'b0;
      q_neg   <= 1'b0;
      q_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (a_valid) begin
            cap   <= a;
            state <= ABS;
          end
        end
        ABS: begin
          state <= SHIFT;
          if (cap[OVF_BIT]) begin
            // overflow skips conversion; the blank code flows out as digits
            q_err <= 1'b1;
            q_neg <= 1'b0;
            bcd   <= {DIGITS{BCD_BLANK}};
            cnt   <= '0;
          end else begin
            q_err <= 1'b0;
            q_neg <= cap[W-1];
            mag   <= mag_abs;
            bcd   <= '0;
            cnt   <= CW'(W);
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            bcd <= {bcd_adj[BW-2:0], mag[W-1]};
            mag <= {mag[W-1:0], 1'b0};
            cnt <= cnt - 1'b1;
          end else begin
            dig     <= bcd;
            q_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (q_ready) begin
            q_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Directed bench for result_bcd_formatter.
// Hand-computed vectors, sampled 1 time unit after the rising edge.
module tb_result_bcd_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] a;
  logic        a_valid;
  logic        a_ready;
  logic        q_ready;
  logic        q_valid;
  logic        q_neg;
  logic        q_err;
  logic [3:0]  q_d2;
  logic [3:0]  q_d1;
  logic [3:0]  q_d0;

  int total = 0;
  int bad = 0;

  result_bcd_formatter dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .q_ready(q_ready),
    .q_valid(q_valid),
    .q_neg(q_neg),
    .q_err(q_err),
    .q_d2(q_d2),
    .q_d1(q_d1),
    .q_d0(q_d0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {q_neg, q_err, q_d2, q_d1, q_d0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one transaction: accept, measure latency, optional back-pressure hold
  task automatic run(input string tag, input logic [10:0] v,
                     input int lat, input int hold, input logic [13:0] exp);
    int n;
    int k;
    logic [13:0] held;
    q_ready = (hold == 0);
    n = 0;
    while (!a_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rdy_wait"}, n, 0);
    a = v;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    a = 11'h000;
    k = 0;
    while (!q_valid && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_out"}, outs(), exp);
    held = outs();
    for (int i = 0; i < hold; i++) begin
      a = 11'h123;
      a_valid = i[0];
      tick();
      chk({tag, "_hold_v"}, q_valid, 1'b1);
      chk({tag, "_hold_o"}, outs(), held);
      chk({tag, "_hold_r"}, a_ready, 1'b0);
    end
    a_valid = 1'b0;
    q_ready = 1'b1;
    tick();
    chk({tag, "_vdrop"}, q_valid, 1'b0);
    chk({tag, "_rdy"}, a_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    a = '0;
    a_valid = 1'b0;
    q_ready = 1'b1;
    tick();
    tick();
    chk("rst_out", {q_valid, outs()}, 15'h0000);
    chk("rst_rdy", a_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_rdy", a_ready, 1'b1);

    run("p123", 11'h07B, 12, 0, {2'b00, 12'h123});
    run("m512", 11'h200, 12, 0, {2'b10, 12'h512});
    run("m1", 11'h3FF, 12, 0, {2'b10, 12'h001});
    run("zero", 11'h000, 12, 0, {2'b00, 12'h000});
    run("ovf", 11'h47B, 2, 0, {2'b01, 12'hFFF});
    run("hold", 11'h1FF, 12, 5, {2'b00, 12'h511});

    // reset during the 4th SHIFT cycle of a conversion
    q_ready = 1'b1;
    a = 11'h07B;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_out", {q_valid, outs()}, 15'h0000);
    chk("mid_rst_rdy", a_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rel_rdy", a_ready, 1'b1);
    run("post", 11'h1FF, 12, 0, {2'b00, 12'h511});

    run("b1", 11'h001, 12, 0, {2'b00, 12'h001});
    run("b2", 11'h3F6, 12, 0, {2'b10, 12'h010});
    run("b3", 11'h064, 12, 0, {2'b00, 12'h100});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
